binary_bcd_seq: RTL and testbench
=================================

# binary_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It is the next generation of the team's combinational 8-bit tens/ones converter. It generalises input width and digit count, and adds valid/ready handshakes on both sides and a significant-digit count. It sits between binary datapath producers and display or serial-print consumers that need decimal digits.

## Interface
- `WIDTH`, 8, binary input width in bits; must be ≥ 1.
- `DIGITS`, 3, number of BCD output digits; elaboration error if 10^DIGITS − 1 < 2^WIDTH − 1.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_data` is presented for conversion.
- `in_ready`  output  1  block can accept a new operand.
- `in_data`  input  WIDTH  unsigned binary operand.
- `out_valid`  output  1  `out_bcd` and `out_ndig` hold a finished result.
- `out_ready`  input  1  consumer accepts the result.
- `out_bcd`  output  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], with digit 0 = ones.
- `out_ndig`  output  $clog2(DIGITS+1)  count of significant digits (leading zeros suppressed); 1 for value 0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: load the binary shift register with `in_data`, clear the BCD register, set the bit counter to WIDTH, go to SHIFT.
- SHIFT, each cycle:
  - Every digit ≥ 5 gets +3.
  - Then {BCD, binary} shifts left by 1.
  - The counter decrements.
  - When the counter goes from 1 to 0, go to DONE.
- DONE:
  - `out_valid`=1.
  - `out_bcd` and `out_ndig` stay stable until the handshake.
  - On `out_ready`, go to IDLE.
- `in_ready` = (state == IDLE). `in_valid` in SHIFT or DONE is ignored; the operand is not queued.
- `out_ndig` is computed during the last shift cycle and registered with the final BCD value. It equals the index of the highest nonzero digit + 1, or 1 if all digits are zero.
- Width rules:
  - The add-3 step works on 4-bit digits with no carry between digits.
  - The BCD register is exactly 4*DIGITS bits.
  - Bits shifted out of the top digit are discarded. The parameter check guarantees they are always 0.

## Timing
- Reset values:
  - state = IDLE
  - `in_ready` = 1 (from the cycle after reset deasserts)
  - `out_valid` = 0
  - `out_bcd` = 0
  - `out_ndig` = 1
  - counter and shift registers = 0
- Latency:
  - Operand accepted at rising edge N (`in_valid` & `in_ready` high before edge N).
  - `out_valid` rises after edge N+WIDTH.
- Throughput: with `out_ready` tied high, one conversion every WIDTH+2 cycles (accept, WIDTH shifts, one DONE cycle).
- `out_valid` held with `out_ready` low: outputs stay bit-for-bit stable indefinitely.
- Reset mid-operation, in any state: the next edge forces reset values and the in-flight conversion is lost without producing a result.
- `rst` and `in_valid` high on the same edge: reset wins and the operand is not accepted.
- `out_bcd` is not required to be meaningful while `out_valid`=0, but it must be registered (no combinational path from `in_data`).

## Structure
- Package `bcd_pkg`:
  - state enum (IDLE, SHIFT, DONE)
  - constant function `bcd_digits_needed(width)` used for the parameter check
  - digit width constant 4
- Sub-module `bcd_dabble_digit`: a 4-bit combinational add-3-if-≥5 cell, instantiated DIGITS times via generate.

## Test plan
- WIDTH=8, DIGITS=3, in 0 → `out_bcd`=0x000, `out_ndig`=1, `out_valid` exactly 8 cycles after accept.
- WIDTH=8, in 99 → 0x099, ndig 2; in 255 → 0x255, ndig 3. Also sweep 0..255 against a decimal reference model.
- Backpressure: hold `out_ready` low 20 cycles after result 0x173 (input 173). Outputs stay stable, `in_ready`=0, and a pulsed `in_valid` with value 5 is not converted. After `out_ready` rises, `in_ready` returns the next cycle.
- WIDTH=16, DIGITS=5, in 65535 → `out_bcd`=0x65535, ndig 5, latency 16. Back-to-back inputs with `out_ready`=1 arrive every 18 cycles.
- Assert `rst` 3 cycles into converting 200 → the next cycle shows `out_valid`=0, `out_bcd`=0, `in_ready`=1. A fresh input 42 then yields 0x042, ndig 2.
- Elaboration with WIDTH=10, DIGITS=3 → error (1023 > 999). WIDTH=10, DIGITS=4 builds cleanly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
//   DIGIT_W           : width of one BCD digit
//   bcd_state_e       : converter FSM states
//   bcd_digits_needed : decimal digits needed to hold 2^width - 1
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // Smallest d with 10^d >= 2^width. Valid for width <= 63.
  function automatic int unsigned bcd_digits_needed(input int unsigned width);
    longint unsigned pow2;
    longint unsigned limit;
    int unsigned     d;
    pow2  = 64'(1) << width;
    limit = 64'd10;
    d     = 1;
    while (limit < pow2) begin
      limit = limit * 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble cell: adds 3 to a BCD digit that is 5 or more.
//   digit      : current 4-bit digit
//   adjusted_c : digit after the add-3 correction (combinational)
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted_c
);

  // No carry out of the cell; a valid digit never exceeds 12 after the add.
  assign adjusted_c = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : operand in_data offered
//   in_ready  : converter idle and accepting an operand
//   in_data   : unsigned binary operand (WIDTH bits)
//   out_valid : out_bcd / out_ndig hold a finished result
//   out_ready : consumer takes the result
//   out_bcd   : packed BCD, digit 0 (ones) in bits [3:0]
//   out_ndig  : number of significant digits, 1 for zero
module binary_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DIGIT_W*DIGITS-1:0]     out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]   out_ndig
);

  localparam int unsigned BW = DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned NW = $clog2(DIGITS + 1);

  // Reject parameter sets whose digit count cannot hold the largest operand.
  if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
    $error("binary_bcd_seq: WIDTH must be in 1..63");
  end else if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_bad_digits
    $error("binary_bcd_seq: DIGITS too small for 2^WIDTH-1");
  end

  bcd_state_e       state;
  logic [WIDTH-1:0] bin_reg;
  logic [BW-1:0]    bcd_reg;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    adj_c;
  logic [BW-1:0]    bcd_next_c;

  // Per-digit add-3 correction applied before each shift.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit      (bcd_reg[DIGIT_W*k +: DIGIT_W]),
      .adjusted_c (adj_c[DIGIT_W*k +: DIGIT_W])
    );
  end

  // Shift corrected BCD left, pulling in the binary MSB; top bit falls off.
  assign bcd_next_c = (adj_c << 1) | BW'(bin_reg[WIDTH-1]);

  // Index of highest nonzero digit plus one, minimum 1.
  function automatic logic [NW-1:0] count_digits(input logic [BW-1:0] v);
    logic [NW-1:0] n;
    n = NW'(1);
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (v[DIGIT_W*k +: DIGIT_W] != '0) n = NW'(k + 1);
    end
    return n;
  endfunction

  // Converter FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_ndig  <= NW'(1);
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_reg  <= in_data;
            bcd_reg  <= '0;
            cnt      <= CW'(WIDTH);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bin_reg <= bin_reg << 1;
          bcd_reg <= bcd_next_c;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_bcd   <= bcd_next_c;
            out_ndig  <= count_digits(bcd_next_c);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Self-checking bench for binary_bcd_seq: an 8-bit/3-digit instance and a
// 16-bit/5-digit instance, with a decimal reference model feeding scoreboards.
module tb_binary_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  id8;
  logic [11:0] ob8;
  logic [1:0]  on8;
  logic        iv16, ir16, ov16, or16;
  logic [15:0] id16;
  logic [19:0] ob16;
  logic [2:0]  on16;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] bcd;
    logic [2:0]  ndig;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  binary_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_bcd(ob8), .out_ndig(on8)
  );

  binary_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
    .out_valid(ov16), .out_ready(or16), .out_bcd(ob16), .out_ndig(on16)
  );

  // Decimal reference: repeated division by 10.
  function automatic exp_t ref_model(input int unsigned v);
    exp_t        e;
    int unsigned r;
    r      = v;
    e.bcd  = '0;
    e.ndig = 3'd1;
    for (int k = 0; k < 5; k++) begin
      e.bcd[4*k +: 4] = 4'(r % 10);
      if ((r % 10) != 0) e.ndig = 3'(k + 1);
      r = r / 10;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input int unsigned v, output int acc, output bit to);
    iv8 = 1'b1; id8 = 8'(v); to = 1'b1; acc = 0;
    for (int i = 0; i < 100; i++) begin
      if (ir8) begin
        step(); acc = cyc; to = 1'b0; q8.push_back(ref_model(v));
        break;
      end
      step();
    end
    iv8 = 1'b0;
  endtask

  task automatic wait8(output int seen, output bit to);
    to = 1'b1; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (ov8) begin seen = cyc; to = 1'b0; break; end
      step();
    end
  endtask

  task automatic send16(input int unsigned v, output int acc, output bit to);
    iv16 = 1'b1; id16 = 16'(v); to = 1'b1; acc = 0;
    for (int i = 0; i < 100; i++) begin
      if (ir16) begin
        step(); acc = cyc; to = 1'b0; q16.push_back(ref_model(v));
        break;
      end
      step();
    end
    iv16 = 1'b0;
  endtask

  task automatic wait16(output int seen, output bit to);
    to = 1'b1; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (ov16) begin seen = cyc; to = 1'b0; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    tests++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || ob8 !== 12'h000 || on8 !== 2'd1) begin
      fails++;
      $display("FAIL reset8: got ir=%b ov=%b bcd=%h ndig=%0d, want ir=1 ov=0 bcd=000 ndig=1",
               ir8, ov8, ob8, on8);
    end
    tests++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || ob16 !== 20'h00000 || on16 !== 3'd1) begin
      fails++;
      $display("FAIL reset16: got ir=%b ov=%b bcd=%h ndig=%0d, want ir=1 ov=0 bcd=00000 ndig=1",
               ir16, ov16, ob16, on16);
    end
  endtask

  task automatic test_values();
    int unsigned vals[6] = '{0, 99, 255, 1, 10, 100};
    int   acc, seen;
    bit   to;
    exp_t e;
    foreach (vals[i]) begin
      send8(vals[i], acc, to);
      if (!to) wait8(seen, to);
      tests++;
      if (to) begin
        fails++; $display("FAIL values_timeout: value %0d got no result, want result", vals[i]);
        continue;
      end
      tests++;
      if (seen - acc != 8) begin
        fails++; $display("FAIL latency8: value %0d got %0d cycles, want 8", vals[i], seen - acc);
      end
      e = q8.pop_front();
      tests++;
      if (ob8 !== e.bcd[11:0] || on8 !== e.ndig[1:0]) begin
        fails++;
        $display("FAIL value8: value %0d got bcd=%h ndig=%0d, want bcd=%h ndig=%0d",
                 vals[i], ob8, on8, e.bcd[11:0], e.ndig);
      end
      or8 = 1'b1; step(); or8 = 1'b0;
      tests++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
        fails++; $display("FAIL handshake8: got ov=%b ir=%b, want ov=0 ir=1", ov8, ir8);
      end
    end
  endtask

  task automatic test_sweep();
    int   acc, seen;
    bit   to;
    exp_t e;
    or8 = 1'b1;
    for (int v = 0; v < 256; v++) begin
      send8(v, acc, to);
      if (!to) wait8(seen, to);
      tests++;
      if (to || q8.size() == 0) begin
        fails++; $display("FAIL sweep_timeout: value %0d got no result, want result", v);
        q8.delete();
        continue;
      end
      e = q8.pop_front();
      if (ob8 !== e.bcd[11:0] || on8 !== e.ndig[1:0]) begin
        fails++;
        $display("FAIL sweep8: value %0d got bcd=%h ndig=%0d, want bcd=%h ndig=%0d",
                 v, ob8, on8, e.bcd[11:0], e.ndig);
      end
      step();
    end
    or8 = 1'b0;
  endtask

  task automatic test_backpressure();
    int   acc, seen;
    bit   to;
    bit   stray;
    exp_t e;
    send8(173, acc, to);
    if (!to) wait8(seen, to);
    tests++;
    if (to) begin
      fails++; $display("FAIL bp_timeout: got no result for 173, want result");
      return;
    end
    e = q8.pop_front();
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || ob8 !== e.bcd[11:0] || on8 !== e.ndig[1:0]) begin
        fails++;
        $display("FAIL bp_hold: cycle %0d got ov=%b ir=%b bcd=%h ndig=%0d, want ov=1 ir=0 bcd=%h ndig=%0d",
                 i, ov8, ir8, ob8, on8, e.bcd[11:0], e.ndig);
      end
      if (i == 5) begin iv8 = 1'b1; id8 = 8'd5; end
      step();
      iv8 = 1'b0;
    end
    or8 = 1'b1; step(); or8 = 1'b0;
    tests++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      fails++; $display("FAIL bp_release: got ov=%b ir=%b, want ov=0 ir=1", ov8, ir8);
    end
    stray = 1'b0;
    repeat (12) begin step(); if (ov8 !== 1'b0) stray = 1'b1; end
    tests++;
    if (stray) begin
      fails++; $display("FAIL bp_ignored_input: got out_valid=1, want no result from pulsed input");
    end
  endtask

  task automatic test_wide();
    int   acc, seen;
    bit   to;
    exp_t e;
    send16(65535, acc, to);
    if (!to) wait16(seen, to);
    tests++;
    if (to) begin
      fails++; $display("FAIL wide_timeout: got no result for 65535, want result");
      return;
    end
    tests++;
    if (seen - acc != 16) begin
      fails++; $display("FAIL latency16: got %0d cycles, want 16", seen - acc);
    end
    e = q16.pop_front();
    tests++;
    if (ob16 !== e.bcd || on16 !== e.ndig || e.bcd !== 20'h65535) begin
      fails++;
      $display("FAIL wide16: got bcd=%h ndig=%0d, want bcd=65535 ndig=5", ob16, on16);
    end
    or16 = 1'b1; step(); or16 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned vals[5] = '{65535, 0, 12345, 9, 40000};
    int   acc[$];
    int   idx, got;
    exp_t e;
    idx = 0; got = 0;
    or16 = 1'b1; iv16 = 1'b1; id16 = 16'(vals[0]);
    for (int i = 0; i < 300 && got < 5; i++) begin
      if (ov16) begin
        tests++;
        if (q16.size() == 0) begin
          fails++; $display("FAIL b2b_extra: got unexpected result bcd=%h, want none", ob16);
        end else begin
          e = q16.pop_front();
          if (ob16 !== e.bcd || on16 !== e.ndig) begin
            fails++;
            $display("FAIL b2b16: got bcd=%h ndig=%0d, want bcd=%h ndig=%0d",
                     ob16, on16, e.bcd, e.ndig);
          end
        end
        got++;
      end
      if (iv16 && ir16) begin
        q16.push_back(ref_model(vals[idx]));
        acc.push_back(cyc + 1);
        idx++;
        step();
        if (idx < 5) id16 = 16'(vals[idx]);
        else iv16 = 1'b0;
      end else begin
        step();
      end
    end
    iv16 = 1'b0; or16 = 1'b0;
    tests++;
    if (got != 5) begin
      fails++; $display("FAIL b2b_count: got %0d results, want 5", got);
    end
    for (int k = 1; k < acc.size(); k++) begin
      tests++;
      if (acc[k] - acc[k-1] != 18) begin
        fails++; $display("FAIL b2b_interval: accept %0d got %0d cycles, want 18", k, acc[k] - acc[k-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   acc, seen;
    bit   to;
    bit   stray;
    exp_t e;
    send8(200, acc, to);
    repeat (3) step();
    rst = 1'b1; iv8 = 1'b1; id8 = 8'd77;
    step();
    tests++;
    if (ov8 !== 1'b0 || ob8 !== 12'h000 || ir8 !== 1'b1 || on8 !== 2'd1) begin
      fails++;
      $display("FAIL reset_mid: got ov=%b bcd=%h ir=%b ndig=%0d, want ov=0 bcd=000 ir=1 ndig=1",
               ov8, ob8, ir8, on8);
    end
    rst = 1'b0; iv8 = 1'b0;
    q8.delete();
    stray = 1'b0;
    repeat (12) begin step(); if (ov8 !== 1'b0) stray = 1'b1; end
    tests++;
    if (stray) begin
      fails++; $display("FAIL reset_priority: got out_valid=1, want no result after reset");
    end
    send8(42, acc, to);
    if (!to) wait8(seen, to);
    tests++;
    if (to) begin
      fails++; $display("FAIL reset_fresh_timeout: got no result for 42, want result");
      return;
    end
    e = q8.pop_front();
    tests++;
    if (ob8 !== 12'h042 || on8 !== 2'd2 || ob8 !== e.bcd[11:0]) begin
      fails++; $display("FAIL reset_fresh: got bcd=%h ndig=%0d, want bcd=042 ndig=2", ob8, on8);
    end
    or8 = 1'b1; step(); or8 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; id8 = '0;
    iv16 = 1'b0; or16 = 1'b0; id16 = '0;
    test_reset();
    test_values();
    test_sweep();
    test_backpressure();
    test_wide();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
